// File: rtl/sub_top_video_pkg.sv
// Shared types and default 640x480@60 timing for the video timing generator.
// Optional feature macro: VIDEO_TIMING_SOP_RESYNC_EN (adds the RESYNC state).
package sub_top_video_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam logic DEF_SYNC_POL = 1'b0;

`ifdef VIDEO_TIMING_SOP_RESYNC_EN
    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_RUN       = 2'd1,
        ST_RESYNC    = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_RUN       = 2'd1
    } state_t;
`endif

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/sub_top_sync2.sv
// Two-flop synchronizer for a single level signal crossing into clk.
module sub_top_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: asynchronous active-low reset lives in the sensitivity list so the
    // flops clear without a running clock; state uses non-blocking assignments.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sub_top_video_timing_gen.sv
// VGA timing generator: counts h/v position, paces a pixel stream and drives
// registered RGB/sync/DE. Define VIDEO_TIMING_SOP_RESYNC_EN for SOP realignment.
module sub_top_video_timing_gen
    import sub_top_video_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = DEF_SYNC_POL
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pll_locked,
    input  logic [23:0] in_data,
    input  logic        in_valid,
    input  logic        in_sop,
    output logic        in_ready,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic        frame_start,
    output logic        underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [H_W-1:0] H_ONE      = H_W'(1);
    localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT_END  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] H_SYNC_BEG = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] H_SYNC_END = H_W'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [V_W-1:0] V_ONE      = V_W'(1);
    localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT_END  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] V_SYNC_BEG = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] V_SYNC_END = V_W'(V_ACTIVE + V_FP + V_SYNC);

    logic           lock_s;
    state_t         state;
    state_t         state_nxt;
    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;

    logic h_act;
    logic v_act;
    logic h_sync;
    logic v_sync;
    logic frame_origin;
    logic frame_last;
    logic xfer;
    logic run_ok;
    logic pixel_slot;
    logic show_pix;
    rgb_t pix_in;

    rgb_t rgb_q;
    logic de_q;
    logic hs_q;
    logic vs_q;
    logic fs_q;
    logic uf_q;

    sub_top_sync2 u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_locked),
        .q       (lock_s)
    );

    assign h_act        = (h_cnt < H_ACT_END);
    assign v_act        = (v_cnt < V_ACT_END);
    assign h_sync       = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    assign v_sync       = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
    assign frame_origin = (h_cnt == '0) && (v_cnt == '0);
    assign frame_last   = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign xfer         = in_valid && in_ready;
    assign pix_in       = rgb_t'(in_data);

    // Outputs go idle as soon as the synchronized lock drops, a cycle before
    // the state register catches up.
    assign run_ok     = (state != ST_WAIT_LOCK) && lock_s;
    assign pixel_slot = run_ok && h_act && v_act;

`ifdef VIDEO_TIMING_SOP_RESYNC_EN
    logic sop_seen;
    logic resync_entry;

    // A frame whose first beat lacks SOP is blanked from that very pixel.
    assign resync_entry = (state == ST_RUN) && frame_origin && xfer && !in_sop;
    assign show_pix     = (state == ST_RUN) && !resync_entry;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sop_seen <= 1'b0;
        end else if (state != ST_RESYNC) begin
            sop_seen <= 1'b0;
        end else if (xfer && in_sop) begin
            sop_seen <= 1'b1;
        end
    end
`else
    logic unused_sop;

    assign unused_sop = in_sop;
    assign show_pix   = (state == ST_RUN);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_WAIT_LOCK;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT_LOCK: begin
                if (lock_s) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
`ifdef VIDEO_TIMING_SOP_RESYNC_EN
                end else if (resync_entry) begin
                    state_nxt = ST_RESYNC;
`endif
                end
            end
`ifdef VIDEO_TIMING_SOP_RESYNC_EN
            ST_RESYNC: begin
                // Leave just before the frame origin so the next frame's
                // first beat is displayed.
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                end else if (frame_last && (sop_seen || (xfer && in_sop))) begin
                    state_nxt = ST_RUN;
                end
            end
`endif
            default: state_nxt = ST_WAIT_LOCK;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        case (state)
            ST_RUN:    in_ready = h_act && v_act;
`ifdef VIDEO_TIMING_SOP_RESYNC_EN
            ST_RESYNC: in_ready = 1'b1;
`endif
            default:   in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if ((state == ST_WAIT_LOCK) || !lock_s) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_ONE;
        end else begin
            h_cnt <= h_cnt + H_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q <= '0;
            de_q  <= 1'b0;
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            fs_q  <= 1'b0;
            uf_q  <= 1'b0;
        end else begin
            rgb_q <= (pixel_slot && show_pix && xfer) ? pix_in : '0;
            de_q  <= pixel_slot;
            hs_q  <= (run_ok && h_sync) ? SYNC_POL : ~SYNC_POL;
            vs_q  <= (run_ok && v_sync) ? SYNC_POL : ~SYNC_POL;
            fs_q  <= run_ok && frame_origin;
            uf_q  <= pixel_slot && show_pix && !xfer;
        end
    end

    assign vga_r       = rgb_q.r;
    assign vga_g       = rgb_q.g;
    assign vga_b       = rgb_q.b;
    assign vga_de      = de_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign frame_start = fs_q;
    assign underflow   = uf_q;

endmodule
